// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-lane data memory.
// Holds the access size codes, the FSM state type and the lane-mask and alignment helpers.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_e;

  // Write-enable lanes touched by an access of the given size at the given byte lane.
  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: byte_mask = 4'b0001 << lane;
      SZ_HALF: byte_mask = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: byte_mask = 4'b1111;
      default: byte_mask = 4'b0000;
    endcase
  endfunction

  // Halves need an even address, words a 4-byte boundary; the reserved size never aligns.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: is_aligned = 1'b1;
      SZ_HALF: is_aligned = ~lane[0];
      SZ_WORD: is_aligned = (lane == 2'b00);
      default: is_aligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bytelane_if.sv
// Access bus of the byte-lane data memory.
// The parity_err signal exists only when DMEM_PARITY_EN is defined.
interface dmem_bytelane_if #(
  parameter int ADDR_W = 32
) ();

  logic              mem_rd;
  logic              mem_wrt;
  logic [1:0]        mem_size;
  logic              mem_unsigned;
  logic [ADDR_W-1:0] address;
  logic [31:0]       write_data;
  logic              clear_req;
  logic [31:0]       read_data;
  logic              read_valid;
  logic              misalign_err;
  logic              busy;
`ifdef DMEM_PARITY_EN
  logic              parity_err;
`endif

  modport master (
    output mem_rd, mem_wrt, mem_size, mem_unsigned, address, write_data, clear_req,
    input  read_data, read_valid, misalign_err, busy
`ifdef DMEM_PARITY_EN
    , input parity_err
`endif
  );

  modport slave (
    input  mem_rd, mem_wrt, mem_size, mem_unsigned, address, write_data, clear_req,
    output read_data, read_valid, misalign_err, busy
`ifdef DMEM_PARITY_EN
    , output parity_err
`endif
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for the data memory.
// Stores: replicate right-justified data onto every lane and build the byte mask.
// Loads: shift the addressed lane down, then sign- or zero-extend sub-word results.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        is_unsigned,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_mask,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  assign wr_mask = byte_mask(size, lane);
  assign shifted = load_word >> {lane, 3'b000};

  // Replicate store data so the mask alone selects the destination lanes.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_data = store_data;
    case (size)
      SZ_BYTE: wr_data = {4{store_data[7:0]}};
      SZ_HALF: wr_data = {2{store_data[15:0]}};
      default: wr_data = store_data;
    endcase
  end

  // Extract the addressed lane and extend it; word loads pass straight through.
  always_comb begin
    load_data = 32'h0;
    case (size)
      SZ_BYTE: load_data = is_unsigned ? {24'h0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_data = is_unsigned ? {16'h0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
      SZ_WORD: load_data = load_word;
      default: load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_bytelane.sv
// Byte-addressed data memory for a single-cycle MIPS32 datapath.
// Registered loads with a valid strobe, misalignment reporting and a one-word-per-cycle
// clear sweep after reset or on clear_req. Define DMEM_PARITY_EN to add per-byte even
// parity storage and the parity_err strobe.
module dmem_bytelane
  import dmem_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  dmem_bytelane_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  state_e         state;
  logic [AW-1:0]  ptr;
  logic [31:0]    mem [DEPTH];

  logic [AW-1:0]  idx;
  logic [1:0]     lane;
  logic           accept;
  logic           aligned;
  logic           do_rd;
  logic           do_wr;
  logic [31:0]    rd_word;
  logic [31:0]    wr_data;
  logic [3:0]     wr_mask;
  logic [31:0]    load_data;
  logic           unused_addr;

  // Address bits above the array alias onto it.
  assign unused_addr = ^bus.address;

  assign idx     = bus.address[AW+1:2];
  assign lane    = bus.address[1:0];
  assign accept  = (state == IDLE);
  assign aligned = is_aligned(bus.mem_size, lane);
  assign do_rd   = accept & bus.mem_rd;
  assign do_wr   = accept & bus.mem_wrt & aligned;
  assign rd_word = mem[idx];
  assign bus.busy = (state == CLEAR);

  dmem_lane_align u_align (
    .size        (bus.mem_size),
    .lane        (lane),
    .is_unsigned (bus.mem_unsigned),
    .store_data  (bus.write_data),
    .load_word   (rd_word),
    .wr_data     (wr_data),
    .wr_mask     (wr_mask),
    .load_data   (load_data)
  );

  // Sweep FSM: CLEAR walks every word once, IDLE serves accesses until clear_req.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      case (state)
        CLEAR: begin
          ptr <= ptr + AW'(1);
          if (ptr == AW'(DEPTH - 1)) state <= IDLE;
        end
        default: begin
          if (bus.clear_req) begin
            state <= CLEAR;
            ptr   <= '0;
          end
        end
      endcase
    end
  end

  // Storage array: zeroed by the sweep, byte-masked on accepted aligned stores.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; the sweep engine zeroes it, which keeps it mappable to RAM.
    if (state == CLEAR) begin
      mem[ptr] <= 32'h0;
    end else if (do_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask[b]) mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Load result and status strobes; read_data holds between accepted reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.read_data    <= 32'h0;
      bus.read_valid   <= 1'b0;
      bus.misalign_err <= 1'b0;
    end else begin
      bus.read_valid   <= do_rd;
      bus.misalign_err <= accept & (bus.mem_rd | bus.mem_wrt) & ~aligned;
      if (do_rd) bus.read_data <= aligned ? load_data : 32'h0;
    end
  end

`ifdef DMEM_PARITY_EN
  logic [3:0] par_mem [DEPTH];
  logic [3:0] rd_par_calc;
  logic [3:0] rd_mask;

  assign rd_mask = byte_mask(bus.mem_size, lane);

  // Even parity: the stored bit equals the XOR of the byte, so a clean byte re-computes equal.
  always_comb begin
    rd_par_calc = 4'h0;
    for (int b = 0; b < 4; b++) rd_par_calc[b] = ^rd_word[8*b +: 8];
  end

  // Parity storage follows the array writes lane for lane.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      par_mem[ptr] <= 4'h0;
    end else if (do_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask[b]) par_mem[idx][b] <= ^wr_data[8*b +: 8];
      end
    end
  end

  // Flag any accessed lane whose stored parity disagrees with its data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bus.parity_err <= 1'b0;
    else          bus.parity_err <= do_rd & aligned & |(rd_mask & (par_mem[idx] ^ rd_par_calc));
  end
`endif

endmodule

// File: tb/tb_dmem_bytelane.sv
// Self-checking bench for dmem_bytelane: directed steps followed by random accesses,
// all compared against a byte-array reference model. Parity steps run only when
// DMEM_PARITY_EN is defined.
module tb_dmem_bytelane;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 32;
  localparam int NBYTES = DEPTH * 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0]  model_mem [NBYTES];
  logic [31:0] exp_rdata;
  logic [31:0] last_rdata;

  dmem_bytelane_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_bytelane #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (byte array, little-endian lanes) ----------------
  function automatic bit model_aligned(input logic [1:0] sz, input logic [31:0] a);
    case (sz)
      2'd0:    return 1'b1;
      2'd1:    return (a % 2) == 0;
      2'd2:    return (a % 4) == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
    int unsigned b;
    longint v;
    b = a % NBYTES;
    case (sz)
      2'd0: begin
        v = model_mem[b];
        if (!uns && v >= 128) v -= 256;
      end
      2'd1: begin
        v = model_mem[b] + 256 * model_mem[b+1];
        if (!uns && v >= 32768) v -= 65536;
      end
      default: v = model_mem[b] + 256 * model_mem[b+1] + 65536 * model_mem[b+2]
                   + 16777216 * model_mem[b+3];
    endcase
    return v[31:0];
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    int unsigned b;
    int n;
    b = a % NBYTES;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    for (int i = 0; i < n; i++) model_mem[b + i] = d[8*i +: 8];
  endtask

  task automatic model_clear();
    for (int i = 0; i < NBYTES; i++) model_mem[i] = 8'h00;
  endtask

  // One access launched at a negedge; results sampled at the following negedge.
  task automatic access(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input logic clr,
                        input string tag);
    bit al;
    al = model_aligned(sz, addr);
    bus.mem_rd       = rd;
    bus.mem_wrt      = wr;
    bus.mem_size     = sz;
    bus.mem_unsigned = uns;
    bus.address      = addr;
    bus.write_data   = wd;
    bus.clear_req    = clr;
    if (rd) exp_rdata = al ? model_load(addr, sz, uns) : 32'h0;
    @(negedge clk);
    bus.mem_rd    = 1'b0;
    bus.mem_wrt   = 1'b0;
    bus.clear_req = 1'b0;
    check({tag, ".valid"},    32'(bus.read_valid),   32'(rd));
    check({tag, ".misalign"}, 32'(bus.misalign_err), 32'((rd | wr) & !al));
    check({tag, ".rdata"},    bus.read_data,         exp_rdata);
`ifdef DMEM_PARITY_EN
    check({tag, ".parity"},   32'(bus.parity_err),   32'h0);
`endif
    last_rdata = bus.read_data;
    if (wr && al) model_store(addr, sz, wd);
    if (clr) begin
      check({tag, ".busy_after_clear"}, 32'(bus.busy), 32'h1);
      model_clear();
    end
  endtask

  // Count negedges with busy high (bounded); optionally hold a read and poke clear_req.
  task automatic sweep_measure(input logic hold_rd, input int poke_at,
                               output int cycles, output int rv_seen);
    cycles  = 0;
    rv_seen = 0;
    bus.mem_rd   = hold_rd;
    bus.mem_size = 2'd2;
    bus.address  = 32'h10;
    for (int i = 0; i < 4 * DEPTH; i++) begin
      if (!bus.busy) break;
      bus.clear_req = (cycles == poke_at);
      cycles++;
      if (bus.read_valid) rv_seen++;
      @(negedge clk);
    end
    bus.mem_rd    = 1'b0;
    bus.clear_req = 1'b0;
  endtask

  initial begin
    int cyc;
    int rv;
    int nonzero;
    logic [31:0] a;
    logic [1:0]  sz;
    logic        rd, wr, uns;

    bus.mem_rd = 1'b0; bus.mem_wrt = 1'b0; bus.mem_size = 2'd0; bus.mem_unsigned = 1'b0;
    bus.address = '0; bus.write_data = '0; bus.clear_req = 1'b0;
    model_clear();
    exp_rdata = 32'h0;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("reset.rdata",    bus.read_data,           32'h0);
    check("reset.valid",    32'(bus.read_valid),     32'h0);
    check("reset.misalign", 32'(bus.misalign_err),   32'h0);
    check("reset.busy",     32'(bus.busy),           32'h1);
`ifdef DMEM_PARITY_EN
    check("reset.parity",   32'(bus.parity_err),     32'h0);
`endif

    // ---- 1: sweep length after reset, reads dropped while busy ----
    reset_n = 1'b1;
    sweep_measure(1'b1, -1, cyc, rv);
    check("sweep1.cycles", 32'(cyc), 32'(DEPTH));
    check("sweep1.no_valid", 32'(rv), 32'h0);
    @(negedge clk);
    check("sweep1.rv_after", 32'(bus.read_valid), 32'h0);

    // ---- 2: word store, byte store, word/byte loads ----
    access(0, 1, 2'd2, 0, 32'h8, 32'h11223344, 0, "sw8");
    access(0, 1, 2'd0, 0, 32'h9, 32'h000000AA, 0, "sb9");
    access(1, 0, 2'd2, 0, 32'h8, 32'h0, 0, "lw8");
    check("lw8.literal", last_rdata, 32'h1122AA44);
    access(1, 0, 2'd0, 0, 32'h9, 32'h0, 0, "lb9");
    check("lb9.literal", last_rdata, 32'hFFFFFFAA);
    access(1, 0, 2'd0, 1, 32'h9, 32'h0, 0, "lbu9");
    check("lbu9.literal", last_rdata, 32'h000000AA);

    // ---- 3: half store, signed/unsigned half loads ----
    access(0, 1, 2'd1, 0, 32'h6, 32'h00008001, 0, "sh6");
    access(1, 0, 2'd1, 0, 32'h6, 32'h0, 0, "lh6");
    check("lh6.literal", last_rdata, 32'hFFFF8001);
    access(1, 0, 2'd1, 1, 32'h6, 32'h0, 0, "lhu6");
    check("lhu6.literal", last_rdata, 32'h00008001);

    // ---- 4: misaligned accesses leave memory untouched ----
    access(1, 0, 2'd2, 0, 32'h2, 32'h0, 0, "lw2_mis");
    access(0, 1, 2'd1, 0, 32'h5, 32'hBEEF, 0, "sh5_mis");
    access(0, 1, 2'd3, 0, 32'h4, 32'hDEAD, 0, "sz3_mis");
    access(1, 0, 2'd2, 0, 32'h4, 32'h0, 0, "lw4_after_mis");
    check("lw4.literal", last_rdata, 32'h80010000);
    access(0, 0, 2'd0, 0, 32'h0, 32'h0, 0, "idle_hold");

    // ---- 5: read-before-write on a combined access ----
    access(0, 1, 2'd2, 0, 32'h0, 32'h5, 0, "sw0_old");
    access(1, 1, 2'd2, 0, 32'h0, 32'h9, 0, "rw0");
    check("rw0.literal", last_rdata, 32'h5);
    access(1, 0, 2'd2, 0, 32'h0, 32'h0, 0, "lw0_new");
    check("lw0.literal", last_rdata, 32'h9);

    // ---- address aliasing above the array ----
    access(0, 1, 2'd2, 0, 32'hABC0_0000 | 32'h20, 32'hCAFEF00D, 0, "sw_alias");
    access(1, 0, 2'd2, 0, 32'h20, 32'h0, 0, "lw_alias");
    check("alias.literal", last_rdata, 32'hCAFEF00D);

    // ---- random accesses against the model ----
    for (int n = 0; n < 400; n++) begin
      a   = ($urandom & ~32'(NBYTES - 1)) | 32'($urandom_range(0, 127));
      sz  = 2'($urandom_range(0, 3));
      rd  = 1'($urandom_range(0, 1));
      wr  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      access(rd, wr, sz, uns, a, $urandom, 0, "rand");
    end

    // ---- 6a: read with clear_req completes, clear_req ignored mid-sweep ----
    access(0, 1, 2'd2, 0, 32'h8, 32'h12345678, 0, "sw8_pre");
    access(1, 0, 2'd2, 0, 32'h8, 32'h0, 1, "lw8_clear");
    check("lw8_clear.literal", last_rdata, 32'h12345678);
    sweep_measure(1'b0, 5, cyc, rv);
    check("sweep2.cycles", 32'(cyc), 32'(DEPTH));

    // ---- 6b: reset pulsed mid-sweep restarts it ----
    access(0, 1, 2'd2, 0, 32'h30, 32'h0BADF00D, 0, "sw30");
    access(1, 0, 2'd2, 0, 32'h30, 32'h0, 0, "lw30");
    bus.clear_req = 1'b1;
    @(negedge clk);
    bus.clear_req = 1'b0;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst.rdata", bus.read_data,         32'h0);
    check("midrst.valid", 32'(bus.read_valid),   32'h0);
    check("midrst.busy",  32'(bus.busy),         32'h1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_rdata = 32'h0;
    model_clear();
    sweep_measure(1'b0, -1, cyc, rv);
    check("sweep3.cycles", 32'(cyc), 32'(DEPTH));
    nonzero = 0;
    for (int w = 0; w < DEPTH; w++) begin
      access(1, 0, 2'd2, 0, 32'(4 * w), 32'h0, 0, "zero_scan");
      if (last_rdata != 32'h0) nonzero++;
    end
    check("zero_scan.nonzero", 32'(nonzero), 32'h0);

`ifdef DMEM_PARITY_EN
    // ---- parity: corrupt one stored parity bit and read it back ----
    access(0, 1, 2'd2, 0, 32'h20, 32'h01020304, 0, "sw_par");
    dut.par_mem[8][1] = ~dut.par_mem[8][1];
    bus.mem_rd = 1'b1; bus.mem_size = 2'd2; bus.address = 32'h20;
    @(negedge clk);
    bus.mem_rd = 1'b0;
    check("parity.err",   32'(bus.parity_err), 32'h1);
    check("parity.valid", 32'(bus.read_valid), 32'h1);
    check("parity.rdata", bus.read_data,       32'h01020304);
    exp_rdata = 32'h01020304;
    access(0, 1, 2'd2, 0, 32'h20, 32'h0, 0, "par_repair");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
